read_burst_issuer: RTL and testbench
====================================

# read_burst_issuer

Upstream request stage for the read-RAM path. Accepts a burst command (start address, word count), splits it into per-word read addresses on the request stream, and collects the returned data in order into a credit-bounded response FIFO. Delivers the data downstream with tlast on the final word. Issue is throttled so that requests in flight plus buffered words never exceed MAX_OUTSTANDING.

## Interface
- ADDR_WIDTH, 48: request address width.
- DATA_WIDTH, 64: returned data width.
- LEN_WIDTH, 16: burst length field width, in words.
- STRIDE, 8: address increment per word, in bytes.
- MAX_OUTSTANDING, 4: response FIFO depth and credit limit (>=1).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- cmd_tvalid / cmd_tready  in / out  1  command handshake.
- cmd_addr  in  ADDR_WIDTH  burst start address.
- cmd_len  in  LEN_WIDTH  burst length in words.
- req_addr_tvalid / req_addr_tready  out / in  1  request handshake.
- req_addr_tdata  out  ADDR_WIDTH  word read address.
- bak_data_tvalid / bak_data_tready  in / out  1  response handshake.
- bak_data_tdata  in  DATA_WIDTH  returned data.
- out_tvalid / out_tready  out / in  1  output handshake.
- out_tdata  out  DATA_WIDTH  data word.
- out_tlast  out  1  last word of burst.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at burst completion.
- err  out  1  sticky: response received with nothing pending.

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: cmd_tready=1. On cmd handshake, latch addr and len; set issue_left = out_left = len.
  - len != 0: go to ISSUE.
  - len == 0: stay in IDLE; done pulses the next cycle; no request or output is generated.
- ISSUE: present the current address when issue_left != 0 and credit < MAX_OUTSTANDING.
  - On request handshake: address += STRIDE (wraps modulo 2^ADDR_WIDTH), issue_left--, credit++.
  - When issue_left reaches 0, go to DRAIN.
- DRAIN: wait until out_left == 0, then pulse done and return to IDLE.
- credit counts requests issued but not yet popped from the output (in flight plus buffered). Width is clog2(MAX_OUTSTANDING+1).
  - Issue and pop in the same cycle: credit unchanged.
- bak_data_tready is tied to 1; the credit limit guarantees FIFO space.
  - A response arriving while pending (credit - fifo_count) == 0 is dropped and sets err.
- The FIFO preserves order. out_tlast = 1 when out_left == 1. Each output handshake decrements out_left and credit.
- cmd_tready is 0 outside IDLE.

## Timing
- Reset values: cmd_tready=1, req_addr_tvalid=0, req_addr_tdata=0, out_tvalid=0, out_tdata=0, out_tlast=0, busy=0, done=0, err=0. All counters and the FIFO are cleared.
- All outputs are registered.
- First request is valid on the cycle after the command handshake.
- Issue rate is 1 per cycle while credit allows. req_addr_tvalid, once high, holds with stable data until req_addr_tready.
- A response accepted at edge N is visible on out_tvalid after edge N+1 if the FIFO was empty.
- Output rate is 1 per cycle. out_tvalid holds until out_tready.
- done asserts one cycle after the handshake of the tlast word; the next command is accepted that same cycle.
- Reset mid-burst: everything returns to reset values. Responses that arrive later are dropped and set err.
- err clears only on reset.

## Test plan
- cmd addr=0x1000, len=1 -> one request 0x1000; response 0xA5 -> out_tdata=0xA5, tlast=1; done one cycle after the output handshake.
- MAX_OUTSTANDING=4, len=8, addr=0, out_tready=0, responses returned immediately -> exactly 4 requests (0x0,0x8,0x10,0x18) issued, then stall. Raise out_tready -> remaining 4 issued; 8 words output in order, tlast only on the 8th.
- addr=2^48-8, len=2 -> requests 0xFFFFFFFFFFF8 then 0x0.
- len=0 -> command accepted, no request, no output, done one cycle later, busy stays 0.
- bak_data_tvalid pulsed in IDLE -> err=1, out_tvalid stays 0. err stays 1 through a subsequent normal burst.
- len=6, assert rstn=0 after 3 requests -> next cycle busy=0, cmd_tready=1, credit=0, out_tvalid=0; a late response sets err.

Source files
------------

// File: rtl/read_burst_issuer.sv
// read_burst_issuer: splits a burst command into per-word read requests and returns the data in order, credit-bounded.
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   cmd_*                      burst command (start address, length in words)
//   req_addr_*                 per-word read address stream
//   bak_data_*                 returned read data (always accepted)
//   out_*                      in-order data to downstream, tlast on the final word
//   busy, done, err            status: not idle, completion pulse, sticky orphan-response flag
module read_burst_issuer #(
    parameter int ADDR_WIDTH      = 48,
    parameter int DATA_WIDTH      = 64,
    parameter int LEN_WIDTH       = 16,
    parameter int STRIDE          = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_tvalid,
    output logic                  cmd_tready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  req_addr_tvalid,
    input  logic                  req_addr_tready,
    output logic [ADDR_WIDTH-1:0] req_addr_tdata,
    input  logic                  bak_data_tvalid,
    output logic                  bak_data_tready,
    input  logic [DATA_WIDTH-1:0] bak_data_tdata,
    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic [DATA_WIDTH-1:0] out_tdata,
    output logic                  out_tlast,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  issue_left_q, issue_left_d, out_left_q, out_left_d;
    logic [CW-1:0]         credit_q, credit_d, fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [MAX_OUTSTANDING];
    logic [DATA_WIDTH-1:0] mem_d [MAX_OUTSTANDING];
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  req_valid_q, req_valid_d, out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d, done_q, done_d, err_q, err_d;
    logic                  cmd_hs, req_hs, push, load, pop;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
    endfunction
    assign cmd_tready      = state_q == IDLE;
    assign busy            = state_q != IDLE;
    assign req_addr_tvalid = req_valid_q;
    assign req_addr_tdata  = addr_q;
    assign bak_data_tready = 1'b1;
    assign out_tvalid      = out_valid_q;
    assign out_tdata       = out_data_q;
    assign out_tlast       = out_last_q;
    assign done            = done_q;
    assign err             = err_q;
    always_comb begin
        cmd_hs       = cmd_tvalid && state_q == IDLE;
        req_hs       = req_valid_q && req_addr_tready;
        pop          = out_valid_q && out_tready;
        // the output register counts as buffered, so pending = credit - (fifo + output reg)
        push         = bak_data_tvalid && credit_q != fifo_cnt_q + CW'(out_valid_q);
        load         = fifo_cnt_q != '0 && (!out_valid_q || out_tready);
        state_d      = state_q;
        addr_d       = addr_q;
        issue_left_d = issue_left_q;
        out_left_d   = out_left_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        mem_d        = mem_q;
        done_d       = 1'b0;
        err_d        = err_q || (bak_data_tvalid && !push);
        if (cmd_hs) begin
            addr_d       = cmd_addr;
            issue_left_d = cmd_len;
            out_left_d   = cmd_len;
            state_d      = cmd_len != '0 ? ISSUE : IDLE;
            done_d       = cmd_len == '0;
        end
        if (req_hs) begin
            addr_d       = addr_q + ADDR_WIDTH'(STRIDE);
            issue_left_d = issue_left_q - 1'b1;
        end
        if (pop) out_left_d = out_left_q - 1'b1;
        if (push) begin
            mem_d[wr_ptr_q] = bak_data_tdata;
            wr_ptr_d        = nxt(wr_ptr_q);
        end
        if (load) rd_ptr_d = nxt(rd_ptr_q);
        credit_d    = credit_q + CW'(req_hs) - CW'(pop);
        fifo_cnt_d  = fifo_cnt_q + CW'(push) - CW'(load);
        out_valid_d = load || (out_valid_q && !out_tready);
        out_data_d  = load ? mem_q[rd_ptr_q] : out_data_q;
        // a word loaded while the current one leaves sees out_left one lower than now
        out_last_d  = load ? (out_valid_q ? out_left_q == LEN_WIDTH'(2) : out_left_q == LEN_WIDTH'(1))
                           : out_last_q && !pop;
        if (state_q == ISSUE && issue_left_d == '0) state_d = DRAIN;
        if (state_q == DRAIN && out_left_d == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
        req_valid_d = state_d == ISSUE && issue_left_d != '0 && credit_d < CW'(MAX_OUTSTANDING);
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            issue_left_q <= '0;
            out_left_q   <= '0;
            credit_q     <= '0;
            fifo_cnt_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_q        <= '{default: '0};
            out_data_q   <= '0;
            req_valid_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            issue_left_q <= issue_left_d;
            out_left_q   <= out_left_d;
            credit_q     <= credit_d;
            fifo_cnt_q   <= fifo_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_q        <= mem_d;
            out_data_q   <= out_data_d;
            req_valid_q  <= req_valid_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end
endmodule

// File: tb/tb_read_burst_issuer.sv
// tb_read_burst_issuer: scoreboard bench for read_burst_issuer with a queued read responder.
module tb_read_burst_issuer;
    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_tvalid, cmd_tready;
    logic [47:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        req_addr_tvalid, req_addr_tready;
    logic [47:0] req_addr_tdata;
    logic        bak_data_tvalid, bak_data_tready;
    logic [63:0] bak_data_tdata;
    logic        out_tvalid, out_tready, out_tlast;
    logic [63:0] out_tdata;
    logic        busy, done, err;
    always #5 clk = ~clk;
    read_burst_issuer dut (
        .clk(clk), .rstn(rstn),
        .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .req_addr_tvalid(req_addr_tvalid), .req_addr_tready(req_addr_tready), .req_addr_tdata(req_addr_tdata),
        .bak_data_tvalid(bak_data_tvalid), .bak_data_tready(bak_data_tready), .bak_data_tdata(bak_data_tdata),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata), .out_tlast(out_tlast),
        .busy(busy), .done(done), .err(err)
    );
    typedef struct {logic [63:0] d; logic l;} out_t;
    int          vec_n = 0, mis_n = 0, req_hs_n = 0;
    logic [47:0] exp_req[$];
    out_t        exp_out[$];
    logic [63:0] rdq[$];
    int          pend_q[$];
    bit          inject = 0, done_exp = 0;
    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vec_n++;
        if (act !== exp) begin
            mis_n++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask
    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic send_cmd(logic [47:0] a, logic [15:0] l);
        int t = 0;
        cmd_tvalid = 1'b1;
        cmd_addr   = a;
        cmd_len    = l;
        @(negedge clk);
        while (!cmd_tready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("cmd_accept", t < 50, 1);
        cyc(1);
        cmd_tvalid = 1'b0;
    endtask
    task automatic burst(logic [47:0] a, logic [15:0] l, logic [63:0] base);
        for (int i = 0; i < int'(l); i++) begin
            exp_req.push_back(a + 48'(8 * i));
            rdq.push_back(base + 64'(i));
            exp_out.push_back('{d: base + 64'(i), l: i == int'(l) - 1});
        end
        send_cmd(a, l);
    endtask
    task automatic wait_idle(string name, int max);
        int t = 0;
        while (t < max && (busy || exp_out.size() != 0 || exp_req.size() != 0)) begin
            @(negedge clk);
            t++;
        end
        chk(name, t < max, 1);
        cyc(2);
    endtask
    // monitor: checks every request and output handshake against the scoreboard
    initial begin
        out_t e;
        forever begin
            @(negedge clk);
            if (done_exp) begin
                chk("done_pulse", done, 1);
                chk("done_cmd_tready", cmd_tready, 1);
                done_exp = 0;
            end
            if (rstn && req_addr_tvalid && req_addr_tready) begin
                req_hs_n++;
                pend_q.push_back(1);
                vec_n++;
                if (exp_req.size() == 0) begin
                    mis_n++;
                    $display("FAIL req_unexpected: got %0h, want none", req_addr_tdata);
                end else begin
                    vec_n--;
                    chk("req_addr", req_addr_tdata, exp_req.pop_front());
                end
            end
            if (rstn && out_tvalid && out_tready) begin
                if (exp_out.size() == 0) begin
                    vec_n++;
                    mis_n++;
                    $display("FAIL out_unexpected: got %0h, want none", out_tdata);
                end else begin
                    e = exp_out.pop_front();
                    chk("out_tdata", out_tdata, e.d);
                    chk("out_tlast", out_tlast, e.l);
                    if (e.l) done_exp = 1;
                end
            end
        end
    end
    // responder: one response per accepted request, the cycle after, using queued data
    initial begin
        bak_data_tvalid = 1'b0;
        bak_data_tdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            bak_data_tvalid = 1'b0;
            if (inject) begin
                bak_data_tvalid = 1'b1;
                bak_data_tdata  = 64'hBAD;
                inject = 0;
            end else if (pend_q.size() != 0) begin
                void'(pend_q.pop_front());
                if (rdq.size() != 0) begin
                    bak_data_tvalid = 1'b1;
                    bak_data_tdata  = rdq.pop_front();
                end
            end
        end
    end
    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end
    initial begin
        int n0;
        rstn = 1'b0; cmd_tvalid = 1'b0; cmd_addr = '0; cmd_len = '0;
        req_addr_tready = 1'b1; out_tready = 1'b1;
        cyc(3);
        @(negedge clk);
        chk("rst_cmd_tready", cmd_tready, 1);
        chk("rst_req_valid", req_addr_tvalid, 0);
        chk("rst_req_data", req_addr_tdata, 0);
        chk("rst_out_valid", out_tvalid, 0);
        chk("rst_out_data", out_tdata, 0);
        chk("rst_out_last", out_tlast, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_bak_ready", bak_data_tready, 1);
        cyc(1);
        rstn = 1'b1;
        cyc(1);
        // single word
        exp_req.push_back(48'h1000);
        rdq.push_back(64'hA5);
        exp_out.push_back('{d: 64'hA5, l: 1'b1});
        send_cmd(48'h1000, 16'd1);
        @(negedge clk);
        chk("first_req_valid", req_addr_tvalid, 1);
        chk("first_req_busy", busy, 1);
        chk("first_req_cmd_tready", cmd_tready, 0);
        wait_idle("len1_complete", 50);
        // credit stall with output blocked
        out_tready = 1'b0;
        n0 = req_hs_n;
        burst(48'h0, 16'd8, 64'h100);
        cyc(15);
        @(negedge clk);
        chk("stall_req_count", req_hs_n - n0, 4);
        chk("stall_req_valid", req_addr_tvalid, 0);
        chk("stall_out_valid", out_tvalid, 1);
        chk("stall_out_data", out_tdata, 64'h100);
        chk("stall_out_last", out_tlast, 0);
        cyc(1);
        out_tready = 1'b1;
        wait_idle("len8_complete", 100);
        chk("len8_req_count", req_hs_n - n0, 8);
        // address wrap
        exp_req.push_back(48'hFFFF_FFFF_FFF8);
        exp_req.push_back(48'h0);
        rdq.push_back(64'h11);
        rdq.push_back(64'h22);
        exp_out.push_back('{d: 64'h11, l: 1'b0});
        exp_out.push_back('{d: 64'h22, l: 1'b1});
        send_cmd(48'hFFFF_FFFF_FFF8, 16'd2);
        wait_idle("wrap_complete", 50);
        // zero length
        n0 = req_hs_n;
        send_cmd(48'h2000, 16'd0);
        @(negedge clk);
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        chk("len0_cmd_tready", cmd_tready, 1);
        @(negedge clk);
        chk("len0_done_clear", done, 0);
        cyc(4);
        chk("len0_no_req", req_hs_n - n0, 0);
        chk("len0_no_out", out_tvalid, 0);
        // orphan response in idle
        @(negedge clk);
        inject = 1;
        repeat (3) @(negedge clk);
        chk("orphan_err", err, 1);
        chk("orphan_out_valid", out_tvalid, 0);
        cyc(1);
        burst(48'h3000, 16'd2, 64'h300);
        wait_idle("after_err_complete", 50);
        chk("err_sticky", err, 1);
        // reset mid-burst after three requests
        out_tready = 1'b0;
        exp_req.push_back(48'h5000);
        exp_req.push_back(48'h5008);
        exp_req.push_back(48'h5010);
        n0 = req_hs_n;
        send_cmd(48'h5000, 16'd6);
        for (int t = 0; t < 20 && req_hs_n - n0 < 3; t++) cyc(1);
        req_addr_tready = 1'b0;
        chk("rst_mid_req_count", req_hs_n - n0, 3);
        rstn = 1'b0;
        cyc(1);
        @(negedge clk);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_cmd_tready", cmd_tready, 1);
        chk("rst_mid_out_valid", out_tvalid, 0);
        chk("rst_mid_req_valid", req_addr_tvalid, 0);
        chk("rst_mid_err", err, 0);
        cyc(1);
        pend_q.delete();
        rstn = 1'b1;
        req_addr_tready = 1'b1;
        @(negedge clk);
        inject = 1;
        repeat (3) @(negedge clk);
        chk("late_resp_err", err, 1);
        chk("late_resp_out_valid", out_tvalid, 0);
        // credit must be back at zero: a full window issues with output blocked
        cyc(1);
        n0 = req_hs_n;
        burst(48'h6000, 16'd4, 64'h600);
        cyc(10);
        chk("post_rst_credit", req_hs_n - n0, 4);
        out_tready = 1'b1;
        wait_idle("post_rst_complete", 50);
        chk("leftover_req", exp_req.size(), 0);
        chk("leftover_out", exp_out.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_n, mis_n);
        $finish;
    end
endmodule
